mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL take parameter DEPTH_WORDS, default 16384, giving word-array depth (64 KiB), power of two.
REQ-002 The block SHALL take parameter LATENCY, default 2, giving load response delay in cycles, legal range 1..4.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 proc2mem_command  input  2  bus command: BUS_NONE, BUS_LOAD or BUS_STORE; value 3 is illegal.
REQ-007 proc2mem_addr  input  32  byte address of the request.
REQ-008 proc2mem_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-009 proc2mem_size  input  2  access size: BYTE, HALF or WORD.
REQ-010 mem2proc_response  output  4  same-cycle accept tag; 0 = rejected or idle.
REQ-011 mem2proc_data  output  32  load data, aligned full word; 0 when mem2proc_tag is 0.
REQ-012 mem2proc_tag  output  4  tag of the completing load; 0 = no completion this cycle.

Function
REQ-013 A request SHALL be accepted when the command is LOAD or STORE, the address is aligned to its size and the word index is below DEPTH_WORDS; mem2proc_response SHALL then equal next_tag combinationally in that cycle.
REQ-014 Idle, illegal-command, misaligned or out-of-range requests SHALL give mem2proc_response=0 and cause no state change.
REQ-015 next_tag SHALL advance on every accepted request: 1..15, then wrap to 1; 0 is never issued.
REQ-016 An accepted STORE SHALL write at the accepting posedge, byte lanes enabled by size and addr[1:0] (BYTE: 1 lane, HALF: 2 lanes, WORD: 4 lanes), with data shifted to the lane position; other lanes SHALL be unchanged.
REQ-017 An accepted STORE SHALL produce no completion on mem2proc_tag.
REQ-018 An accepted LOAD SHALL read the aligned word in its accept cycle; that word SHALL appear with its tag on mem2proc_data/mem2proc_tag exactly LATENCY cycles after the accepting posedge, for exactly one cycle.
REQ-019 A LOAD accepted the cycle after a STORE to the same word SHALL return the stored data; no extra bypass is required, since only one command arrives per cycle.
REQ-020 Back-to-back LOADs every cycle SHALL be sustained with no bubbles; up to LATENCY loads SHALL be in flight at once, each completing in issue order.
REQ-021 Sign or zero extension and lane extraction SHALL NOT be performed; that belongs to the requester.
REQ-022 Memory contents SHALL be readable and writable hierarchically by the testbench for program preload and dump.

Reset
REQ-023 While rst is high: mem2proc_tag=0, mem2proc_data=0, mem2proc_response=0, next_tag=1, all pipeline valid bits cleared.
REQ-024 Loads in flight when reset asserts SHALL be discarded, and none SHALL complete after reset.
REQ-025 The memory array SHALL NOT be reset.
REQ-026 A request presented in the first cycle after reset deasserts SHALL be accepted with tag 1.

Structure
REQ-027 Bus command encodings (BUS_NONE/BUS_LOAD/BUS_STORE) and size encodings (BYTE/HALF/WORD) SHALL come from the shared system definitions, shared with the processor.
REQ-028 The LATENCY-deep response delay line {valid, tag[3:0], data[31:0]} SHALL be one sub-module, mem_resp_pipe, parameterized by LATENCY.
REQ-029 The array, byte-lane write logic, accept check and tag counter SHALL live in mem_responder.

Verification
REQ-030 Preload word 0x40=0xDEADBEEF; LOAD WORD @0x40 after reset -> response=1 same cycle; tag=1, data=0xDEADBEEF exactly 2 cycles later, tag=0 the cycle after.
REQ-031 STORE BYTE 0xAA @0x41 over 0x00000000, then LOAD @0x40 next cycle -> data=0x0000AA00; STORE HALF 0x1234 @0x42 -> word=0x1234AA00.
REQ-032 Each of these gives response=0 and leaves next_tag unchanged: LOAD HALF @0x1; STORE WORD @0x2; command 3; address 0x10000.
REQ-033 16 consecutive accepted LOADs -> tags 1..15 then 1; completions every cycle in issue order with correct data.
REQ-034 Assert rst with 2 loads in flight -> no completion ever appears for them; first post-reset request gets tag 1.
REQ-035 Run with LATENCY=1 and LATENCY=4 -> completion exactly that many cycles after accept.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the processor/memory interface: command and size encodings
// plus the byte-lane helper used by the store path.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_e;

    typedef enum logic [1:0] {
        BYTE = 2'h0,
        HALF = 2'h1,
        WORD = 2'h2
    } mem_size_e;

    localparam int unsigned TagW  = 4;
    localparam int unsigned DataW = 32;

    // Byte lanes touched by an access of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] off);
        logic [3:0] m;
        case (size)
            BYTE:    m = 4'b0001;
            HALF:    m = 4'b0011;
            WORD:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency load response delay line carrying {valid, tag, data}; outputs are zero
// whenever the emerging stage holds no valid completion.
module mem_resp_pipe
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [TagW-1:0]  in_tag_i,
    input  logic [DataW-1:0] in_data_i,
    output logic [TagW-1:0]  out_tag_o,
    output logic [DataW-1:0] out_data_o
);

    logic [LATENCY-1:0]            valid_q;
    logic [LATENCY-1:0][TagW-1:0]  tag_q;
    logic [LATENCY-1:0][DataW-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            tag_q[0]   <= in_tag_i;
            data_q[0]  <= in_data_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_tag_o  = valid_q[LATENCY-1] ? tag_q[LATENCY-1]  : '0;
    assign out_data_o = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;

endmodule

// File: rtl/mem_responder.sv
// Word-array memory model answering processor bus requests: same-cycle accept tag,
// byte-lane stores, and tagged load completions after a fixed LATENCY.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [31:0] proc2mem_data,
    input  logic [1:0]  proc2mem_size,
    output logic [3:0]  mem2proc_response,
    output logic [31:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    // Not reset; the testbench preloads and dumps it hierarchically.
    logic [31:0] mem [DEPTH_WORDS];

    logic [IdxW-1:0] word_idx;
    logic            is_load, is_store, aligned, in_range, accept;
    logic [3:0]      lane_en;
    logic [31:0]     wdata, rdata;
    logic [3:0]      next_tag_q, next_tag_d;

    always_comb begin
        is_load  = (proc2mem_command == BUS_LOAD);
        is_store = (proc2mem_command == BUS_STORE);
        word_idx = proc2mem_addr[IdxW+1:2];
        in_range = (proc2mem_addr[31:IdxW+2] == '0);
        case (proc2mem_size)
            BYTE:    aligned = 1'b1;
            HALF:    aligned = ~proc2mem_addr[0];
            WORD:    aligned = (proc2mem_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        accept  = ~rst & (is_load | is_store) & aligned & in_range;
        lane_en = lane_mask(proc2mem_size, proc2mem_addr[1:0]);
        wdata   = proc2mem_data << {proc2mem_addr[1:0], 3'b000};
        rdata   = mem[word_idx];

        next_tag_d = next_tag_q;
        if (accept) begin
            next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
        end
        mem2proc_response = accept ? next_tag_q : 4'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_tag_q <= 4'd1;
        end else begin
            next_tag_q <= next_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_store) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (accept & is_load),
        .in_tag_i   (next_tag_q),
        .in_data_i  (rdata),
        .out_tag_o  (mem2proc_tag),
        .out_data_o (mem2proc_data)
    );

endmodule
